// File: rtl/btn_debounce_bank_pkg.sv
// Shared definitions for the button-conditioner bank.
// Provides the hold-FSM state type and a helper that sizes the hold counter
// so it can count up to the larger of the long-press and repeat intervals
// without wrapping.
package btn_pkg;

    // Per-channel hold tracking: released, pressed but not yet long, long-held.
    typedef enum logic [1:0] {
        IDLE,
        PRESSED,
        HELD
    } hold_state_t;

    // Width needed to hold any value 0..max(hold_ticks, repeat_ticks).
    function automatic int hold_cnt_width(input int hold_ticks, input int repeat_ticks);
        int max_ticks;
        max_ticks = (hold_ticks > repeat_ticks) ? hold_ticks : repeat_ticks;
        return (max_ticks < 1) ? 1 : $clog2(max_ticks + 1);
    endfunction

endpackage

// File: rtl/btn_debounce_bank_if.sv
// Bundle of the control-panel button signals.
//   CE          : shared timing tick
//   BTN_IN      : raw button inputs, 1 = pressed
//   BTN_STATE   : debounced levels
//   PRESS_CEO   : one-clock strobe on each debounced rise
//   RELEASE_CEO : one-clock strobe on each debounced fall
//   LONG_CEO    : one-clock strobe when the hold time is reached
//   REPEAT_CEO  : one-clock auto-repeat strobe while long-held
// master = the side driving buttons and CE, slave = the conditioner.
interface btn_debounce_bank_if #(
    parameter int N_CH = 4
);

    logic            CE;
    logic [N_CH-1:0] BTN_IN;
    logic [N_CH-1:0] BTN_STATE;
    logic [N_CH-1:0] PRESS_CEO;
    logic [N_CH-1:0] RELEASE_CEO;
    logic [N_CH-1:0] LONG_CEO;
    logic [N_CH-1:0] REPEAT_CEO;

    modport master (
        output CE,
        output BTN_IN,
        input  BTN_STATE,
        input  PRESS_CEO,
        input  RELEASE_CEO,
        input  LONG_CEO,
        input  REPEAT_CEO
    );

    modport slave (
        input  CE,
        input  BTN_IN,
        output BTN_STATE,
        output PRESS_CEO,
        output RELEASE_CEO,
        output LONG_CEO,
        output REPEAT_CEO
    );

endinterface

// File: rtl/btn_debounce_bank_ch.sv
// One button channel: two-flop synchroniser, saturating-stability debounce
// counter, hold FSM and registered event strobes.
//   CLK, RST    : clock and asynchronous active-high reset
//   ce          : timing tick, every counter advances only when high
//   btn_in      : raw asynchronous button input
//   btn_state   : debounced level
//   press_ceo   : strobe on the edge btn_state rises
//   release_ceo : strobe on the edge btn_state falls
//   long_ceo    : strobe HOLD_TICKS ticks after the press
//   repeat_ceo  : strobe every REPEAT_TICKS ticks after the long press
// Every output comes straight from a flop.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int CNTR_WIDTH   = 4,
    parameter int HOLD_TICKS   = 64,
    parameter int REPEAT_TICKS = 16,
    parameter int REPEAT_EN    = 1
) (
    input  logic CLK,
    input  logic RST,
    input  logic ce,
    input  logic btn_in,
    output logic btn_state,
    output logic press_ceo,
    output logic release_ceo,
    output logic long_ceo,
    output logic repeat_ceo
);

    localparam int HCW = hold_cnt_width(HOLD_TICKS, REPEAT_TICKS);
    localparam logic [HCW-1:0] HOLD_LAST   = HCW'(HOLD_TICKS - 1);
    localparam logic [HCW-1:0] REPEAT_LAST = HCW'(REPEAT_TICKS - 1);

    logic                  sync_d;
    logic                  sync_s1;
    logic                  level;
    logic [CNTR_WIDTH-1:0] db_cnt;

    logic upd;
    logic rise_upd;
    logic fall_upd;

    hold_state_t    hold_state;
    hold_state_t    hold_state_next;
    logic [HCW-1:0] hold_cnt;
    logic [HCW-1:0] hold_cnt_next;
    logic           long_next;
    logic           repeat_next;

    logic press_q;
    logic release_q;
    logic long_q;
    logic repeat_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync_d  <= 1'b0;
            sync_s1 <= 1'b0;
        end else begin
            sync_d  <= btn_in;
            sync_s1 <= sync_d;
        end
    end

    // Any tick on which the synchronised input agrees with the filtered
    // level restarts the stability count, which is what rejects bounces.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            db_cnt <= '0;
            level  <= 1'b0;
        end else if (sync_s1 == level) begin
            db_cnt <= '0;
        end else if (ce) begin
            if (db_cnt == '1) begin
                level  <= sync_s1;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // The disagreement check keeps a stale all-ones count (left over from an
    // input that returned on the same edge it saturated) from firing an event.
    assign upd      = ce && (sync_s1 != level) && (db_cnt == '1);
    assign rise_upd = upd &&  sync_s1;
    assign fall_upd = upd && !sync_s1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            hold_state <= IDLE;
            hold_cnt   <= '0;
        end else begin
            hold_state <= hold_state_next;
            hold_cnt   <= hold_cnt_next;
        end
    end

    // A release is tested first so it wins over a LONG or REPEAT threshold
    // landing on the same tick.
    always_comb begin
        hold_state_next = hold_state;
        hold_cnt_next   = hold_cnt;
        long_next       = 1'b0;
        repeat_next     = 1'b0;
        if (fall_upd) begin
            hold_state_next = IDLE;
            hold_cnt_next   = '0;
        end else begin
            case (hold_state)
                IDLE: begin
                    if (rise_upd) begin
                        hold_state_next = PRESSED;
                        hold_cnt_next   = '0;
                    end
                end
                PRESSED: begin
                    if (ce) begin
                        if (hold_cnt == HOLD_LAST) begin
                            long_next       = 1'b1;
                            hold_state_next = HELD;
                            hold_cnt_next   = '0;
                        end else begin
                            hold_cnt_next = hold_cnt + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if ((REPEAT_EN != 0) && ce) begin
                        if (hold_cnt == REPEAT_LAST) begin
                            repeat_next   = 1'b1;
                            hold_cnt_next = '0;
                        end else begin
                            hold_cnt_next = hold_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    hold_state_next = IDLE;
                    hold_cnt_next   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
        end else begin
            press_q   <= rise_upd;
            release_q <= fall_upd;
            long_q    <= long_next;
            repeat_q  <= repeat_next;
        end
    end

    assign btn_state   = level;
    assign press_ceo   = press_q;
    assign release_ceo = release_q;
    assign long_ceo    = long_q;
    assign repeat_ceo  = (REPEAT_EN != 0) ? repeat_q : 1'b0;

endmodule

// File: rtl/btn_debounce_bank.sv
// Multi-channel button conditioner for the PWM control panel.
//   CLK, RST : clock and asynchronous active-high reset
//   bus      : slave side of btn_debounce_bank_if (CE, BTN_IN in; debounced
//              levels and PRESS/RELEASE/LONG/REPEAT strobes out)
// N_CH independent btn_debounce_ch instances, outputs concatenated by index.
// The interface must be instantiated with the same N_CH.
module btn_debounce_bank
    import btn_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CNTR_WIDTH   = 4,
    parameter int HOLD_TICKS   = 64,
    parameter int REPEAT_TICKS = 16,
    parameter int REPEAT_EN    = 1
) (
    input logic              CLK,
    input logic              RST,
    btn_debounce_bank_if.slave bus
);

    logic [N_CH-1:0] state_vec;
    logic [N_CH-1:0] press_vec;
    logic [N_CH-1:0] release_vec;
    logic [N_CH-1:0] long_vec;
    logic [N_CH-1:0] repeat_vec;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .CNTR_WIDTH  (CNTR_WIDTH),
            .HOLD_TICKS  (HOLD_TICKS),
            .REPEAT_TICKS(REPEAT_TICKS),
            .REPEAT_EN   (REPEAT_EN)
        ) u_ch (
            .CLK        (CLK),
            .RST        (RST),
            .ce         (bus.CE),
            .btn_in     (bus.BTN_IN[i]),
            .btn_state  (state_vec[i]),
            .press_ceo  (press_vec[i]),
            .release_ceo(release_vec[i]),
            .long_ceo   (long_vec[i]),
            .repeat_ceo (repeat_vec[i])
        );
    end

    assign bus.BTN_STATE   = state_vec;
    assign bus.PRESS_CEO   = press_vec;
    assign bus.RELEASE_CEO = release_vec;
    assign bus.LONG_CEO    = long_vec;
    assign bus.REPEAT_CEO  = repeat_vec;

endmodule

// File: tb/tb_btn_debounce_bank.sv
// Self-checking bench for btn_debounce_bank: two instances (auto-repeat on
// and off) share the same stimulus and are compared every clock against a
// behavioural model, plus scenario tables and hand-written corner cases.
module tb_btn_debounce_bank;

    localparam int N    = 4;
    localparam int CW   = 4;
    localparam int HOLD = 8;
    localparam int REP  = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         ce  = 1'b0;
    logic [N-1:0] btn = '0;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    btn_debounce_bank_if #(.N_CH(N)) bus_rep ();
    btn_debounce_bank_if #(.N_CH(N)) bus_norep ();

    assign bus_rep.CE       = ce;
    assign bus_rep.BTN_IN   = btn;
    assign bus_norep.CE     = ce;
    assign bus_norep.BTN_IN = btn;

    btn_debounce_bank #(
        .N_CH(N), .CNTR_WIDTH(CW), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .REPEAT_EN(1)
    ) dut_rep (
        .CLK(CLK), .RST(RST), .bus(bus_rep)
    );

    btn_debounce_bank #(
        .N_CH(N), .CNTR_WIDTH(CW), .HOLD_TICKS(HOLD), .REPEAT_TICKS(REP), .REPEAT_EN(0)
    ) dut_norep (
        .CLK(CLK), .RST(RST), .bus(bus_norep)
    );

    // Model: a 2-deep sample delay, a run length of CE ticks during which the
    // delayed sample disagrees with the level (16 in a row flips it), and a
    // count of CE ticks since the press from which LONG/REPEAT are derived.
    logic [N-1:0] m_d, m_s1, m_lvl;
    int           m_run   [N];
    bit           m_held  [N];
    int           m_ticks [N];
    logic [N-1:0] e_press, e_rel, e_long, e_rep;

    task automatic model_reset();
        m_d = '0; m_s1 = '0; m_lvl = '0;
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int i = 0; i < N; i++) begin
            m_run[i] = 0; m_held[i] = 0; m_ticks[i] = 0;
        end
    endtask

    task automatic model_step(input logic [N-1:0] b, input logic c);
        e_press = '0; e_rel = '0; e_long = '0; e_rep = '0;
        for (int i = 0; i < N; i++) begin
            if (m_s1[i] != m_lvl[i]) begin
                if (c) m_run[i]++;
            end else begin
                m_run[i] = 0;
            end
            if (m_run[i] == (1 << CW)) begin
                m_run[i] = 0;
                m_lvl[i] = m_s1[i];
                if (m_lvl[i]) begin
                    e_press[i] = 1'b1; m_held[i] = 1; m_ticks[i] = 0;
                end else begin
                    e_rel[i] = 1'b1; m_held[i] = 0;
                end
            end else if (m_held[i] && c) begin
                m_ticks[i]++;
                if (m_ticks[i] == HOLD) e_long[i] = 1'b1;
                else if (m_ticks[i] > HOLD && ((m_ticks[i] - HOLD) % REP) == 0) e_rep[i] = 1'b1;
            end
        end
        m_s1 = m_d;
        m_d  = b;
    endtask

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic int pack_rep();
        return int'({bus_rep.BTN_STATE, bus_rep.PRESS_CEO, bus_rep.RELEASE_CEO,
                     bus_rep.LONG_CEO, bus_rep.REPEAT_CEO});
    endfunction

    function automatic int pack_norep();
        return int'({bus_norep.BTN_STATE, bus_norep.PRESS_CEO, bus_norep.RELEASE_CEO,
                     bus_norep.LONG_CEO, bus_norep.REPEAT_CEO});
    endfunction

    // Drive inputs, advance one clock, update the model and compare both DUTs.
    task automatic applyStimulus(input logic [N-1:0] b, input logic c);
        btn = b;
        ce  = c;
        @(posedge CLK);
        if (RST) model_reset();
        else     model_step(b, c);
        #1;
        checkOutput("model_rep", pack_rep(), int'({m_lvl, e_press, e_rel, e_long, e_rep}));
        checkOutput("model_norep", pack_norep(), int'({m_lvl, e_press, e_rel, e_long, 4'b0000}));
    endtask

    typedef struct {
        int ch;
        int hi1;
        int gap;
        int hi_end;
        int exp_press;
        int exp_long;
        int exp_rep;
        int exp_rel;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [N-1:0] b;
        int first_press, n_press, n_long, n_rep, n_long_off, n_rep_off, first_rel;
        int ce_cnt, found;

        // Edge numbers are counted from the first edge that samples the change.
        vecs[0] = '{0, 20, 0, 20, 17, 1, 2, 37};
        vecs[1] = '{2, 40, 0, 40, 17, 1, 7, 57};
        vecs[2] = '{1, 10, 0, 10, -1, 0, 0, -1};
        vecs[3] = '{3, 15, 0, 15, -1, 0, 0, -1};
        vecs[4] = '{1, 16, 0, 16, 17, 1, 1, 33};
        vecs[5] = '{3, 25, 0, 25, 17, 1, 4, 42};
        vecs[6] = '{1, 10, 3, 60, 30, 1, 9, 77};

        model_reset();
        for (int k = 0; k < 3; k++) applyStimulus('0, 1'b1);
        checkOutput("reset_state", pack_rep(), 0);
        RST = 1'b0;

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < 40; k++) applyStimulus('0, 1'b1);
            first_press = -1; n_press = 0; n_long = 0; n_rep = 0;
            n_long_off = 0; n_rep_off = 0; first_rel = -1;
            for (int k = 0; k < 100; k++) begin
                b = '0;
                b[vecs[v].ch] = (k < vecs[v].hi1) ||
                                (k >= vecs[v].hi1 + vecs[v].gap && k < vecs[v].hi_end);
                applyStimulus(b, 1'b1);
                if (bus_rep.PRESS_CEO[vecs[v].ch]) begin
                    n_press++;
                    if (first_press < 0) first_press = k;
                end
                if (bus_rep.RELEASE_CEO[vecs[v].ch] && first_rel < 0) first_rel = k;
                if (bus_rep.LONG_CEO[vecs[v].ch])     n_long++;
                if (bus_rep.REPEAT_CEO[vecs[v].ch])   n_rep++;
                if (bus_norep.LONG_CEO[vecs[v].ch])   n_long_off++;
                if (bus_norep.REPEAT_CEO[vecs[v].ch]) n_rep_off++;
            end
            checkOutput($sformatf("v%0d_press_edge", v), first_press, vecs[v].exp_press);
            checkOutput($sformatf("v%0d_press_count", v), n_press, (vecs[v].exp_press >= 0) ? 1 : 0);
            checkOutput($sformatf("v%0d_long_count", v), n_long, vecs[v].exp_long);
            checkOutput($sformatf("v%0d_repeat_count", v), n_rep, vecs[v].exp_rep);
            checkOutput($sformatf("v%0d_release_edge", v), first_rel, vecs[v].exp_rel);
            checkOutput($sformatf("v%0d_norep_long", v), n_long_off, vecs[v].exp_long);
            checkOutput($sformatf("v%0d_norep_repeat", v), n_rep_off, 0);
        end

        // CE only every 4th cycle: the level must flip on the 16th counted tick.
        for (int k = 0; k < 40; k++) applyStimulus('0, 1'b1);
        ce_cnt = 0; found = -1;
        for (int k = 0; k < 200 && found < 0; k++) begin
            applyStimulus(4'b1000, (k % 4) == 0);
            if (k >= 2 && (k % 4) == 0) ce_cnt++;
            if (bus_rep.PRESS_CEO[3]) found = k;
        end
        checkOutput("ce4_press_edge", found, 64);
        checkOutput("ce4_ce_ticks", ce_cnt, 16);
        checkOutput("ce4_state", int'(bus_rep.BTN_STATE[3]), 1);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("ce4_press_width", int'(bus_rep.PRESS_CEO[3]), 0);
        found = -1;
        for (int k = 0; k < 100 && found < 0; k++) begin
            applyStimulus(4'b1000, (k % 4) == 0);
            if (bus_rep.LONG_CEO[3]) found = k;
        end
        checkOutput("ce4_long_seen", (found >= 0) ? 1 : 0, 1);
        applyStimulus(4'b1000, 1'b0);
        checkOutput("ce4_long_width", int'(bus_rep.LONG_CEO[3]), 0);
        for (int k = 0; k < 120; k++) applyStimulus('0, 1'b1);

        // Reset during HELD on ch2, button kept high through it.
        for (int k = 0; k < 30; k++) applyStimulus(4'b0100, 1'b1);
        #2;
        RST = 1'b1;
        model_reset();
        #1;
        checkOutput("rst_async_rep", pack_rep(), 0);
        checkOutput("rst_async_norep", pack_norep(), 0);
        for (int k = 0; k < 3; k++) applyStimulus(4'b0100, 1'b1);
        RST = 1'b0;
        found = -1;
        for (int k = 0; k < 40 && found < 0; k++) begin
            applyStimulus(4'b0100, 1'b1);
            if (bus_rep.PRESS_CEO[2]) found = k;
        end
        checkOutput("rst_fresh_press", found, 17);
        for (int k = 0; k < 60; k++) applyStimulus('0, 1'b1);

        // Random toggling, full-rate CE first, then random CE with a reset pulse.
        b = '0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 29) == 0) b[i] = ~b[i];
            end
            if (cyc == 1500) begin
                #2;
                RST = 1'b1;
                model_reset();
            end
            if (cyc == 1503) RST = 1'b0;
            applyStimulus(b, (cyc < 1000) ? 1'b1 : ($urandom_range(0, 2) != 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
